// File: rtl/fixed_point_pkg.sv
// Shared encodings and saturation helpers for the fixed-point MAC datapath.
package fixed_point_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_MUL  = 2'b01,
    OP_MAC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  // Helpers work on a fixed wide container so any operand width up to MAX_W fits.
  localparam int MAX_W  = 64;
  localparam int WIDE_W = 2 * MAX_W + 2;

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    logic             ovf;
    logic [MAX_W-1:0] val;
  } sat_t;

  function automatic wide_t q_max(input int width);
    wide_t one_s;
    one_s = {{(WIDE_W-1){1'b0}}, 1'b1};
    return (one_s <<< (width - 32'sd1)) - one_s;
  endfunction

  function automatic wide_t q_min(input int width);
    wide_t one_s;
    one_s = {{(WIDE_W-1){1'b0}}, 1'b1};
    return -(one_s <<< (width - 32'sd1));
  endfunction

  // Clamp a sign-extended value into a signed field of the given width.
  function automatic sat_t sat_from_wide(input wide_t value, input int width);
    sat_t  r;
    wide_t hi_s;
    wide_t lo_s;
    hi_s = q_max(width);
    lo_s = q_min(width);
    if (value > hi_s) begin
      r.ovf = 1'b1;
      r.val = hi_s[MAX_W-1:0];
    end else if (value < lo_s) begin
      r.ovf = 1'b1;
      r.val = lo_s[MAX_W-1:0];
    end else begin
      r.ovf = 1'b0;
      r.val = value[MAX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_point_mul_sat.sv
// Signed Q-format multiply, rescale and saturate; shared by MUL and MAC.
// Build with FIXED_POINT_MAC_ROUND_EN to round half toward +inf instead of truncating.
module fixed_point_mul_sat
  import fixed_point_pkg::*;
#(
  parameter int  INT_BITS  = 15,
  parameter int  FRAC_BITS = 16,
  localparam int W         = 1 + INT_BITS + FRAC_BITS
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         ovf
);

  localparam int PW = 2 * W;

`ifdef FIXED_POINT_MAC_ROUND_EN
  localparam logic signed [PW-1:0] ROUND_BIAS = {{(PW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
`endif

  logic signed [PW-1:0] a_ext_s;
  logic signed [PW-1:0] b_ext_s;
  logic signed [PW-1:0] prod_s;
  logic signed [PW-1:0] scaled_s;
  wide_t                wide_s;
  sat_t                 sat_s;
  logic                 unused_s;

  // Full-precision product, optional rounding bias, rescale and clamp
  always_comb begin
    a_ext_s  = {{W{a[W-1]}}, a};
    b_ext_s  = {{W{b[W-1]}}, b};
`ifdef FIXED_POINT_MAC_ROUND_EN
    prod_s   = (a_ext_s * b_ext_s) + ROUND_BIAS;
`else
    prod_s   = a_ext_s * b_ext_s;
`endif
    scaled_s = prod_s >>> FRAC_BITS;
    wide_s   = {{(WIDE_W - PW){scaled_s[PW-1]}}, scaled_s};
    sat_s    = sat_from_wide(wide_s, W);
    res      = sat_s.val[W-1:0];
    ovf      = sat_s.ovf;
    unused_s = ^sat_s.val;
  end

endmodule

// File: rtl/fixed_point_mac.sv
// Two-stage pipelined saturating fixed-point ADD/MUL/MAC/LOAD unit with valid/ready on both sides.
// MUL/MAC rounding is chosen at build time by FIXED_POINT_MAC_ROUND_EN (inside fixed_point_mul_sat).
module fixed_point_mac
  import fixed_point_pkg::*;
#(
  parameter int  INT_BITS  = 15,
  parameter int  FRAC_BITS = 16,
  localparam int W         = 1 + INT_BITS + FRAC_BITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         overflow,
  output logic         sticky_ovf,
  input  logic         sticky_clr
);

  logic         s1_valid_q, s1_valid_d;
  op_e          s1_op_q, s1_op_d;
  logic [W-1:0] s1_a_q, s1_a_d;
  logic [W-1:0] s1_b_q, s1_b_d;
  logic         s2_valid_q, s2_valid_d;
  logic [W-1:0] out_q, out_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] acc_q, acc_d;
  logic         sticky_q, sticky_d;

  logic              adv2_s;
  logic              in_ready_s;
  logic [W-1:0]      mul_res_s;
  logic              mul_ovf_s;
  logic signed [W:0] add_sum_s;
  logic signed [W:0] mac_sum_s;
  sat_t              add_sat_s;
  sat_t              mac_sat_s;
  logic [W-1:0]      res_s;
  logic              res_ovf_s;
  logic [W-1:0]      acc_next_s;
  logic              unused_s;

  function automatic wide_t sext_w1(input logic [W:0] v);
    return {{(WIDE_W - W - 1){v[W]}}, v};
  endfunction

  fixed_point_mul_sat #(
    .INT_BITS  (INT_BITS),
    .FRAC_BITS (FRAC_BITS)
  ) u_mul_sat (
    .a   (s1_a_q),
    .b   (s1_b_q),
    .res (mul_res_s),
    .ovf (mul_ovf_s)
  );

  // Stage-2 result, overflow and next accumulator for the op held in S1
  always_comb begin
    add_sum_s  = {s1_a_q[W-1], s1_a_q} + {s1_b_q[W-1], s1_b_q};
    mac_sum_s  = {acc_q[W-1], acc_q} + {mul_res_s[W-1], mul_res_s};
    add_sat_s  = sat_from_wide(sext_w1(add_sum_s), W);
    mac_sat_s  = sat_from_wide(sext_w1(mac_sum_s), W);
    unused_s   = ^{add_sat_s.val, mac_sat_s.val};
    res_s      = {W{1'b0}};
    res_ovf_s  = 1'b0;
    acc_next_s = acc_q;
    case (s1_op_q)
      OP_ADD: begin
        res_s     = add_sat_s.val[W-1:0];
        res_ovf_s = add_sat_s.ovf;
      end
      OP_MUL: begin
        res_s     = mul_res_s;
        res_ovf_s = mul_ovf_s;
      end
      OP_MAC: begin
        res_s      = mac_sat_s.val[W-1:0];
        res_ovf_s  = mul_ovf_s | mac_sat_s.ovf;
        acc_next_s = mac_sat_s.val[W-1:0];
      end
      OP_LOAD: begin
        res_s      = s1_a_q;
        res_ovf_s  = 1'b0;
        acc_next_s = s1_a_q;
      end
      default: begin
        res_s      = {W{1'b0}};
        res_ovf_s  = 1'b0;
        acc_next_s = acc_q;
      end
    endcase
  end

  // Handshake control and next-state for both stages and the sticky flag
  always_comb begin
    adv2_s     = !s2_valid_q || out_ready;
    in_ready_s = !s1_valid_q || adv2_s;

    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    ovf_d      = ovf_q;
    acc_d      = acc_q;
    sticky_d   = sticky_q;

    if (in_ready_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d = op_e'(op);
        s1_a_d  = a;
        s1_b_d  = b;
      end else begin
        s1_op_d = s1_op_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end

    // The accumulator only moves with the S1->S2 transfer, so a stalled MAC cannot double-count.
    if (adv2_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d = res_s;
        ovf_d = res_ovf_s;
        acc_d = acc_next_s;
      end else begin
        acc_d = acc_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end

    if (s2_valid_q && out_ready && ovf_q) begin
      sticky_d = 1'b1;
    end else if (sticky_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Pipeline, accumulator and sticky state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_ADD;
      s1_a_q     <= {W{1'b0}};
      s1_b_q     <= {W{1'b0}};
      s2_valid_q <= 1'b0;
      out_q      <= {W{1'b0}};
      ovf_q      <= 1'b0;
      acc_q      <= {W{1'b0}};
      sticky_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      ovf_q      <= ovf_d;
      acc_q      <= acc_d;
      sticky_q   <= sticky_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = s2_valid_q;
  assign out        = out_q;
  assign overflow   = ovf_q;
  assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_fixed_point_mac.sv
// Self-checking bench for fixed_point_mac (Q15.16): vector table plus stall, reset and sticky sequences.
module tb_fixed_point_mac;

  localparam int W = 32;
  localparam logic [1:0] T_ADD  = 2'b00;
  localparam logic [1:0] T_MUL  = 2'b01;
  localparam logic [1:0] T_MAC  = 2'b10;
  localparam logic [1:0] T_LOAD = 2'b11;

`ifdef FIXED_POINT_MAC_ROUND_EN
  localparam logic [W-1:0] EXP_RND_POS = 32'h00000001;
  localparam logic [W-1:0] EXP_RND_NEG = 32'h00000000;
`else
  localparam logic [W-1:0] EXP_RND_POS = 32'h00000000;
  localparam logic [W-1:0] EXP_RND_NEG = 32'hFFFFFFFF;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = 32'h0;
  logic [W-1:0] b = 32'h0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out;
  logic         overflow;
  logic         sticky_ovf;
  logic         sticky_clr = 1'b0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_out;
    logic         exp_ovf;
    string        name;
  } vec_t;

  typedef struct {
    logic [W-1:0] out;
    logic         ovf;
    logic         chk_lat;
    int           acc_cyc;
    string        name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int sent_cnt = 0;
  int recv_cnt = 0;

  fixed_point_mac #(
    .INT_BITS  (15),
    .FRAC_BITS (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .overflow   (overflow),
    .sticky_ovf (sticky_ovf),
    .sticky_clr (sticky_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] ex, input logic eo, input string nm);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.exp_out = ex; v.exp_ovf = eo; v.name = nm;
    vecs.push_back(v);
  endtask

  // Drive one beat, wait (bounded) for acceptance, and queue its expected result.
  task automatic send(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic [W-1:0] ex, input logic eo, input logic chk, input string nm);
    exp_t e;
    int   k;
    @(negedge clk);
    op = o; a = va; b = vb; in_valid = 1'b1;
    #1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s accept_timeout: in_ready stayed 0, expected 1", nm);
      in_valid = 1'b0;
    end else begin
      e.out = ex; e.ovf = eo; e.chk_lat = chk; e.acc_cyc = cyc + 1; e.name = nm;
      sb_q.push_back(e);
      @(posedge clk);
      sent_cnt++;
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_drain_pending"}, 64'(sb_q.size()), 64'd0);
  endtask

  // Output monitor: scoreboard pop on each transfer, stability check while stalled.
  initial begin
    exp_t         e;
    logic [W-1:0] hold_out;
    logic         hold_ovf;
    logic         hold_pend;
    hold_pend = 1'b0;
    hold_out  = 32'h0;
    hold_ovf  = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check("stall_hold_valid", 64'(out_valid), 64'd1);
          check("stall_hold_out", 64'(out), 64'(hold_out));
          check("stall_hold_ovf", 64'(overflow), 64'(hold_ovf));
        end
        hold_pend = out_valid && !out_ready;
        hold_out  = out;
        hold_ovf  = overflow;
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: got %0h with empty scoreboard", out);
          end else begin
            e = sb_q.pop_front();
            check({e.name, "_out"}, 64'(out), 64'(e.out));
            check({e.name, "_ovf"}, 64'(overflow), 64'(e.ovf));
            if (e.chk_lat) check({e.name, "_latency"}, 64'(cyc + 1 - e.acc_cyc), 64'd2);
            recv_cnt++;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_low;
    int   k;

    add_vec(T_MUL,  32'h00020000, 32'h00018000, 32'h00030000, 1'b0, "mul_2x1p5");
    add_vec(T_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b1, "add_pos_sat");
    add_vec(T_ADD,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "add_neg_sat");
    add_vec(T_ADD,  32'h00010000, 32'h00020000, 32'h00030000, 1'b0, "add_plain");
    add_vec(T_ADD,  32'hFFFF0000, 32'h00008000, 32'hFFFF8000, 1'b0, "add_mixed");
    add_vec(T_MUL,  32'h00000001, 32'h00008000, EXP_RND_POS,  1'b0, "mul_round_pos");
    add_vec(T_MUL,  32'hFFFFFFFF, 32'h00008000, EXP_RND_NEG,  1'b0, "mul_round_neg");
    add_vec(T_MUL,  32'h7FFF0000, 32'h00020000, 32'h7FFFFFFF, 1'b1, "mul_pos_sat");
    add_vec(T_MUL,  32'h80000000, 32'h00020000, 32'h80000000, 1'b1, "mul_neg_sat");
    add_vec(T_MUL,  32'hFFFE0000, 32'h00018000, 32'hFFFD0000, 1'b0, "mul_neg");
    add_vec(T_MUL,  32'h80000000, 32'h80000000, 32'h7FFFFFFF, 1'b1, "mul_min_min");
    add_vec(T_LOAD, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 1'b0, "load_any");
    add_vec(T_LOAD, 32'h00010000, 32'h00000000, 32'h00010000, 1'b0, "load_one");
    add_vec(T_MAC,  32'h00010000, 32'h00020000, 32'h00030000, 1'b0, "mac_1");
    add_vec(T_MAC,  32'h00010000, 32'h00020000, 32'h00050000, 1'b0, "mac_2");
    add_vec(T_MAC,  32'h00010000, 32'h00020000, 32'h00070000, 1'b0, "mac_3");
    add_vec(T_ADD,  32'h00000000, 32'h00000000, 32'h00000000, 1'b0, "add_keeps_acc");
    add_vec(T_MUL,  32'h00010000, 32'h00010000, 32'h00010000, 1'b0, "mul_keeps_acc");
    add_vec(T_MAC,  32'h00010000, 32'h00020000, 32'h00090000, 1'b0, "mac_4");
    add_vec(T_LOAD, 32'h7FFF0000, 32'h00000000, 32'h7FFF0000, 1'b0, "load_big");
    add_vec(T_MAC,  32'h00010000, 32'h00010000, 32'h7FFFFFFF, 1'b1, "mac_add_sat");
    add_vec(T_MAC,  32'h7FFF0000, 32'h7FFF0000, 32'h7FFFFFFF, 1'b1, "mac_both_sat");
    add_vec(T_LOAD, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, "load_min");
    add_vec(T_MAC,  32'hFFFF0000, 32'h00010000, 32'h80000000, 1'b1, "mac_neg_sat");
    add_vec(T_LOAD, 32'hC0000000, 32'h00000000, 32'hC0000000, 1'b0, "load_neg");
    add_vec(T_MAC,  32'h7FFF0000, 32'h00020000, 32'h3FFFFFFF, 1'b1, "mac_mul_ovf_only");

    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_sticky", 64'(sticky_ovf), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].exp_ovf, 1'b1, vecs[i].name);
    end
    drain("table");
    check("sticky_after_table", 64'(sticky_ovf), 64'd1);

    @(negedge clk);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    #1;
    check("sticky_cleared", 64'(sticky_ovf), 64'd0);

    // Clear coinciding with an overflowing handoff: set must win.
    @(negedge clk);
    out_ready = 1'b0;
    send(T_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, "sticky_race_add");
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("sticky_race_out_valid", 64'(out_valid), 64'd1);
    out_ready  = 1'b1;
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    #1;
    check("sticky_set_wins", 64'(sticky_ovf), 64'd1);
    drain("sticky_race");

    // Backpressure: a 5-cycle out_ready gap inside a MAC stream.
    send(T_LOAD, 32'h00010000, 32'h00000000, 32'h00010000, 1'b0, 1'b0, "bp_load");
    saw_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(T_MAC, 32'h00010000, 32'h00020000, 32'h00010000 + 32'(i + 1) * 32'h00020000,
               1'b0, 1'b0, "bp_mac");
        end
      end
      begin
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          #3;
          if (!in_ready && !saw_low) begin
            saw_low = 1'b1;
            check("bp_in_flight", 64'(sent_cnt - recv_cnt), 64'd2);
          end
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    check("bp_in_ready_dropped", 64'(saw_low), 64'd1);
    drain("backpressure");

    // Reset while S1 and S2 are both occupied and acc = 5.0.
    send(T_LOAD, 32'h00010000, 32'h00000000, 32'h00010000, 1'b0, 1'b1, "rst_load");
    send(T_MAC,  32'h00010000, 32'h00020000, 32'h00030000, 1'b0, 1'b1, "rst_mac1");
    send(T_MAC,  32'h00010000, 32'h00020000, 32'h00050000, 1'b0, 1'b1, "rst_mac2");
    send(T_MAC,  32'h00010000, 32'h00020000, 32'h00070000, 1'b0, 1'b1, "rst_mac3");
    @(negedge clk);
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    check("pre_rst_out", 64'(out), 64'h00050000);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_discarded", 64'(sb_q.size()), 64'd2);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(T_MAC, 32'h00010000, 32'h00010000, 32'h00010000, 1'b0, 1'b1, "post_rst_mac");
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
